// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch unit: PC generation, ITCM read issue, static JAL/backward-branch
// prediction and a credit-controlled fetch queue toward decode (valid/ready).
module ifu_fetch_queue #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter bit              BPRED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            start,
  output logic            itcm_ren,
  output logic [PC_W-1:0] itcm_addr,
  input  logic [31:0]     itcm_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [PC_W-1:0] dec_pc,
  output logic            dec_pred_taken,
  input  logic            flush_flag,
  input  logic [PC_W-1:0] pc_new
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned CR_W  = CNT_W + 1;
  localparam logic [6:0]  OP_JAL = 7'b1101111;
  localparam logic [6:0]  OP_BXX = 7'b1100011;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  resp_pc;
  logic             inflight;
  logic             kill;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      q_instr [FQ_DEPTH];
  logic [PC_W-1:0]  q_pc    [FQ_DEPTH];
  logic             q_pred  [FQ_DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic             pred_taken;
  logic             redirect;
  logic [CR_W-1:0]  credit;
  logic [31:0]      imm_j;
  logic [31:0]      imm_b;
  logic [PC_W-1:0]  target;

  // Predecode of the word returning from the ITCM this cycle.
  always_comb begin
    imm_j      = {{11{itcm_rdata[31]}}, itcm_rdata[31], itcm_rdata[19:12],
                  itcm_rdata[20], itcm_rdata[30:21], 1'b0};
    imm_b      = {{19{itcm_rdata[31]}}, itcm_rdata[31], itcm_rdata[7],
                  itcm_rdata[30:25], itcm_rdata[11:8], 1'b0};
    pred_taken = 1'b0;
    target     = PC_W'(32'(resp_pc) + imm_b);
    if (BPRED_EN) begin
      if (itcm_rdata[6:0] == OP_JAL) begin
        pred_taken = 1'b1;
        target     = PC_W'(32'(resp_pc) + imm_j);
      end else if (itcm_rdata[6:0] == OP_BXX) begin
        pred_taken = imm_b[31];
      end
    end
  end

  // Issue only while the queue can absorb every outstanding response; held off during reset.
  always_comb begin
    pop      = dec_valid & dec_ready;
    push     = inflight & ~kill & ~flush_flag;
    redirect = push & pred_taken;
    credit   = CR_W'(count) + CR_W'(inflight) - CR_W'(pop);
    issue    = rst_ & start & ~flush_flag & (credit < CR_W'(FQ_DEPTH));
  end

  assign itcm_ren       = issue;
  assign itcm_addr      = pc;
  assign dec_valid      = (count != '0);
  assign dec_instr      = q_instr[rd_ptr];
  assign dec_pc         = q_pc[rd_ptr];
  assign dec_pred_taken = q_pred[rd_ptr];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pc       <= RESET_PC;
      resp_pc  <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        q_pred[i]  <= 1'b0;
      end
    end else begin
      inflight <= issue;
      if (issue) resp_pc <= pc;
      if (flush_flag) begin
        pc     <= pc_new;
        kill   <= 1'b0;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // A request issued alongside a taken prediction fetched the wrong path.
        kill <= redirect & issue;
        if (redirect)   pc <= target;
        else if (issue) pc <= pc + PC_W'(4);
        if (push) begin
          q_instr[wr_ptr] <= itcm_rdata;
          q_pc[wr_ptr]    <= resp_pc;
          q_pred[wr_ptr]  <= pred_taken;
          wr_ptr          <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  a_no_full_push: assert property (@(posedge clk) disable iff (!rst_)
    push |-> (count < CNT_W'(FQ_DEPTH)));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: ITCM model, expected-delivery scoreboard with a forked
// monitor, plus directed timing checks for reset, stall, flush and prediction.
module tb_ifu_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
    logic        pred;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_;
  logic        start;
  logic        itcm_ren;
  logic [15:0] itcm_addr;
  logic [31:0] itcm_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [15:0] dec_pc;
  logic        dec_pred_taken;
  logic        flush_flag;
  logic [15:0] pc_new;

  logic [31:0] imem [0:16383];
  exp_t        expq [$];
  logic        armed;
  int          checks;
  int          errors;

  ifu_fetch_queue #(.PC_W(16), .RESET_PC(16'h0000), .FQ_DEPTH(4), .BPRED_EN(1'b1)) dut (
    .clk(clk), .rst_(rst_), .start(start),
    .itcm_ren(itcm_ren), .itcm_addr(itcm_addr), .itcm_rdata(itcm_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken),
    .flush_flag(flush_flag), .pc_new(pc_new)
  );

  always #5 clk = ~clk;

  // ITCM: data one cycle after the read request.
  always @(posedge clk) begin
    if (itcm_ren) itcm_rdata <= imem[itcm_addr[15:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic exp_push(input logic [15:0] pc, input logic [31:0] instr, input logic pred);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.pred = pred;
    expq.push_back(e);
  endtask

  task automatic exp_nops(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) exp_push(first + 16'(4 * i), NOP, 1'b0);
  endtask

  // Pops the scoreboard on every accepted decode beat while armed.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ && armed && dec_valid && dec_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL pop_extra: got pc %h with nothing expected", dec_pc);
        end else begin
          e = expq.pop_front();
          if (dec_pc !== e.pc || dec_instr !== e.instr || dec_pred_taken !== e.pred) begin
            errors++;
            $display("FAIL pop: got pc %h instr %h pred %b expected pc %h instr %h pred %b",
                     dec_pc, dec_instr, dec_pred_taken, e.pc, e.instr, e.pred);
          end
        end
        if (expq.size() == 0) armed = 1'b0;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (armed && n < 60) begin
      step();
      n++;
    end
    if (armed) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d entries still expected after %0d cycles",
               name, expq.size(), n);
      armed = 1'b0;
      expq.delete();
    end
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    start = 1'b0;
    dec_ready = 1'b0;
    flush_flag = 1'b0;
    pc_new = '0;
    armed = 1'b0;
    expq.delete();
    for (int i = 0; i < 16384; i++) imem[i] = NOP;
    step();
    step();
  endtask

  task automatic release_reset(input logic ready);
    rst_ = 1'b1;
    start = 1'b1;
    dec_ready = ready;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    armed = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    do_reset();
    chk("rst_ren", 32'(itcm_ren), 32'd0);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_instr", dec_instr, 32'd0);
    chk("rst_pc", 32'(dec_pc), 32'd0);
    chk("rst_pred", 32'(dec_pred_taken), 32'd0);

    // Sequential NOP stream and first-delivery latency
    exp_nops(16'h0000, 6);
    armed = 1'b1;
    release_reset(1'b1);
    chk("c0_ren", 32'(itcm_ren), 32'd1);
    chk("c0_addr", 32'(itcm_addr), 32'h0);
    step();
    chk("c1_addr", 32'(itcm_addr), 32'h4);
    chk("c1_valid", 32'(dec_valid), 32'd0);
    step();
    chk("c2_addr", 32'(itcm_addr), 32'h8);
    chk("c2_valid", 32'(dec_valid), 32'd1);
    wait_drain("seq");

    // JAL +16 at 0x8: 0xC squashed, next is 0x18
    do_reset();
    imem[2] = 32'h0100_006F;
    exp_nops(16'h0000, 2);
    exp_push(16'h0008, 32'h0100_006F, 1'b1);
    exp_nops(16'h0018, 2);
    armed = 1'b1;
    release_reset(1'b1);
    wait_drain("jal");

    // BEQ -8 at 0x20: backward, predicted taken, loops 0x18..0x20
    do_reset();
    imem[8] = 32'hFE00_0CE3;
    exp_nops(16'h0000, 8);
    exp_push(16'h0020, 32'hFE00_0CE3, 1'b1);
    exp_nops(16'h0018, 2);
    exp_push(16'h0020, 32'hFE00_0CE3, 1'b1);
    exp_nops(16'h0018, 1);
    armed = 1'b1;
    release_reset(1'b1);
    wait_drain("beq_back");

    // BEQ +8 at 0x20: forward, not predicted
    do_reset();
    imem[8] = 32'h0000_0463;
    exp_nops(16'h0000, 8);
    exp_push(16'h0020, 32'h0000_0463, 1'b0);
    exp_nops(16'h0024, 2);
    armed = 1'b1;
    release_reset(1'b1);
    wait_drain("beq_fwd");

    // Decode stall: queue fills to 4, fetch stops, nothing lost
    do_reset();
    release_reset(1'b0);
    repeat (10) step();
    chk("stall_valid", 32'(dec_valid), 32'd1);
    chk("stall_ren", 32'(itcm_ren), 32'd0);
    chk("stall_head", 32'(dec_pc), 32'h0);
    start = 1'b0;
    exp_nops(16'h0000, 4);
    armed = 1'b1;
    dec_ready = 1'b1;
    wait_drain("stall_drain");
    chk("stall_empty", 32'(dec_valid), 32'd0);
    exp_nops(16'h0010, 3);
    armed = 1'b1;
    start = 1'b1;
    wait_drain("stall_resume");

    // Flush with a read in flight and a nearly full queue
    do_reset();
    release_reset(1'b0);
    repeat (4) step();
    flush_flag = 1'b1;
    pc_new = 16'h0100;
    #1;
    chk("flush_no_issue", 32'(itcm_ren), 32'd0);
    step();
    flush_flag = 1'b0;
    #1;
    chk("flush_valid", 32'(dec_valid), 32'd0);
    chk("flush_ren", 32'(itcm_ren), 32'd1);
    chk("flush_addr", 32'(itcm_addr), 32'h100);
    exp_nops(16'h0100, 4);
    armed = 1'b1;
    dec_ready = 1'b1;
    wait_drain("flush");

    // Asynchronous reset mid-stream
    do_reset();
    release_reset(1'b1);
    repeat (5) step();
    rst_ = 1'b0;
    #1;
    chk("arst_valid", 32'(dec_valid), 32'd0);
    chk("arst_instr", dec_instr, 32'd0);
    chk("arst_pc", 32'(dec_pc), 32'd0);
    chk("arst_pred", 32'(dec_pred_taken), 32'd0);
    chk("arst_ren", 32'(itcm_ren), 32'd0);
    step();
    exp_nops(16'h0000, 3);
    armed = 1'b1;
    rst_ = 1'b1;
    #1;
    chk("arst_restart_ren", 32'(itcm_ren), 32'd1);
    chk("arst_restart_addr", 32'(itcm_addr), 32'h0);
    wait_drain("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
